// File: rtl/ad9122_spi_target_regfile_if.sv
// SDIO-side bus of the AD9122 SPI target: chip select, controller data/direction
// and the target's read-data driver.
interface ad9122_spi_target_regfile_if;
    logic i_sen_n;
    logic i_sda;
    logic i_sda_dir;
    logic o_miso;
    logic o_miso_oe;

    modport master (
        output i_sen_n,
        output i_sda,
        output i_sda_dir,
        input  o_miso,
        input  o_miso_oe
    );

    modport slave (
        input  i_sen_n,
        input  i_sda,
        input  i_sda_dir,
        output o_miso,
        output o_miso_oe
    );
endinterface

// File: rtl/ad9122_spi_target_regfile.sv
// AD9122 SPI target with a 128x8 register file, write/read statistics and a debug port.
// Define AD9122_SPI_STREAM_EN to enable streaming (auto-incrementing address) transfers.
module ad9122_spi_target_regfile #(
    parameter logic [6:0] CHIP_ID_ADDR = 7'h1F,
    parameter logic [7:0] CHIP_ID      = 8'h08,
    parameter int         CNT_W        = 16
) (
    input  logic                         o_sclk,
    input  logic                         rst_n,
    ad9122_spi_target_regfile_if.slave   spi,
    output logic [CNT_W-1:0]             o_wr_cnt,
    output logic [CNT_W-1:0]             o_rd_cnt,
    output logic [6:0]                   o_last_addr,
    output logic [7:0]                   o_last_data,
    output logic                         o_contention,
    input  logic [6:0]                   i_dbg_addr,
    output logic [7:0]                   o_dbg_data
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INSTR,
        ST_WDATA,
        ST_RDATA,
        ST_DONE
    } state_t;

    state_t             r_state;
    logic [4:0]         r_bit_cnt;
    logic [6:0]         r_shift;
    logic [6:0]         r_addr;
    logic [7:0]         r_regs [0:127];
    logic [CNT_W-1:0]   r_wr_cnt;
    logic [CNT_W-1:0]   r_rd_cnt;
    logic [6:0]         r_last_addr;
    logic [7:0]         r_last_data;
    logic               r_contention;
    logic [7:0]         r_rd_sh;
    logic               r_miso;
    logic               r_miso_oe;

    logic               w_frame_rst_n;
    logic [7:0]         w_byte;
    logic               w_wr_fire;
    logic               w_rd_fire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [7:0] rd_val(input logic [6:0] a, input logic [7:0] stored);
        return (a == CHIP_ID_ADDR) ? CHIP_ID : stored;
    endfunction

    // Frame tracking restarts whenever chip select is released.
    assign w_frame_rst_n = rst_n & ~spi.i_sen_n;
    assign w_byte        = {r_shift, spi.i_sda};
    assign w_wr_fire     = (r_state == ST_WDATA) && (r_bit_cnt == 5'd15);
    assign w_rd_fire     = (r_state == ST_RDATA) && (r_bit_cnt == 5'd15);

    always_ff @(posedge o_sclk or negedge w_frame_rst_n) begin
        if (!w_frame_rst_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 5'd0;
            r_shift   <= 7'd0;
            r_addr    <= 7'd0;
        end else begin
            r_shift <= w_byte[6:0];
            case (r_state)
                ST_IDLE: begin
                    r_state   <= ST_INSTR;
                    r_bit_cnt <= 5'd1;
                end
                ST_INSTR: begin
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                    if (r_bit_cnt == 5'd7) begin
                        r_addr  <= w_byte[6:0];
                        r_state <= r_shift[6] ? ST_RDATA : ST_WDATA;
                    end
                end
                ST_WDATA, ST_RDATA: begin
                    if (r_bit_cnt == 5'd15) begin
`ifdef AD9122_SPI_STREAM_EN
                        r_bit_cnt <= 5'd8;
                        r_addr    <= r_addr + 7'd1;
`else
                        r_bit_cnt <= 5'd16;
                        r_state   <= ST_DONE;
`endif
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Register file and statistics survive chip-select cycling; only rst_n clears them.
    always_ff @(posedge o_sclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 128; i++) r_regs[i] <= 8'h00;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_last_addr <= 7'd0;
            r_last_data <= 8'd0;
        end else begin
            if (w_wr_fire) begin
                if (r_addr == 7'h00 && w_byte[5]) begin
                    for (int i = 0; i < 128; i++) r_regs[i] <= 8'h00;
                end else if (r_addr != CHIP_ID_ADDR) begin
                    r_regs[r_addr] <= w_byte;
                end
                r_last_addr <= r_addr;
                r_last_data <= w_byte;
                r_wr_cnt    <= sat_inc(r_wr_cnt);
            end
            if (w_rd_fire) r_rd_cnt <= sat_inc(r_rd_cnt);
        end
    end

    // Read data launches on negedges so the controller samples it on posedges 9..16.
    always_ff @(negedge o_sclk or negedge w_frame_rst_n) begin
        if (!w_frame_rst_n) begin
            r_miso_oe <= 1'b0;
            r_miso    <= 1'b0;
            r_rd_sh   <= 8'd0;
        end else if (r_state == ST_RDATA && r_bit_cnt == 5'd8) begin
            r_rd_sh   <= rd_val(r_addr, r_regs[r_addr]);
            r_miso    <= rd_val(r_addr, r_regs[r_addr]) >> 7;
            r_miso_oe <= 1'b1;
        end else if (r_state == ST_RDATA) begin
            r_rd_sh <= {r_rd_sh[6:0], 1'b0};
            r_miso  <= r_rd_sh[6];
        end else begin
            r_miso_oe <= 1'b0;
            r_miso    <= 1'b0;
        end
    end

    always_ff @(negedge o_sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_contention <= 1'b0;
        end else if (r_miso_oe && !spi.i_sda_dir) begin
            r_contention <= 1'b1;
        end
    end

    assign spi.o_miso    = r_miso_oe & r_miso;
    assign spi.o_miso_oe = r_miso_oe;
    assign o_wr_cnt      = r_wr_cnt;
    assign o_rd_cnt      = r_rd_cnt;
    assign o_last_addr   = r_last_addr;
    assign o_last_data   = r_last_data;
    assign o_contention  = r_contention;
    assign o_dbg_data    = rd_val(i_dbg_addr, r_regs[i_dbg_addr]);

endmodule

// File: tb/tb_ad9122_spi_target_regfile.sv
// Scoreboard bench for ad9122_spi_target_regfile: stimulus queues expected writes/read bytes,
// monitors pop and compare as the target reports them.
module tb_ad9122_spi_target_regfile;

    logic        o_sclk;
    logic        rst_n;
    logic [15:0] o_wr_cnt;
    logic [15:0] o_rd_cnt;
    logic [6:0]  o_last_addr;
    logic [7:0]  o_last_data;
    logic        o_contention;
    logic [6:0]  i_dbg_addr;
    logic [7:0]  o_dbg_data;

    ad9122_spi_target_regfile_if spi ();

    ad9122_spi_target_regfile dut (
        .o_sclk       (o_sclk),
        .rst_n        (rst_n),
        .spi          (spi),
        .o_wr_cnt     (o_wr_cnt),
        .o_rd_cnt     (o_rd_cnt),
        .o_last_addr  (o_last_addr),
        .o_last_data  (o_last_data),
        .o_contention (o_contention),
        .i_dbg_addr   (i_dbg_addr),
        .o_dbg_data   (o_dbg_data)
    );

    typedef struct {
        logic [6:0]  a;
        logic [7:0]  d;
        logic [15:0] c;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] rd_q[$];
    int         total = 0;
    int         bad = 0;
    int         oe_rises = 0;
    int         exp_wr = 0;
    int         exp_rd = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b, input logic dir);
        spi.i_sda     = b;
        spi.i_sda_dir = dir;
        #5 o_sclk = 1'b1;
        #5 o_sclk = 1'b0;
    endtask

    // nbits clocks: 8 instruction bits then data bits taken MSB-first from d[15:0].
    task automatic spi_frame(input logic rw, input logic [6:0] a, input logic [15:0] d,
                             input int nbits, input logic rel);
        logic [7:0] ins;
        ins = {rw, a};
        spi.i_sen_n = 1'b0;
        #5;
        for (int i = 0; i < nbits; i++) begin
            if (i < 8) spi_bit(ins[7-i], 1'b0);
            else       spi_bit(d[23-i], rw && rel);
        end
        #5 spi.i_sen_n = 1'b1;
        spi.i_sda_dir = 1'b0;
        #10;
    endtask

    task automatic push_wr(input logic [6:0] a, input logic [7:0] d);
        wr_t e;
        exp_wr++;
        e.a = a;
        e.d = d;
        e.c = 16'(exp_wr);
        wr_q.push_back(e);
    endtask

    task automatic dbg(input logic [6:0] a, input logic [7:0] exp, input string name);
        i_dbg_addr = a;
        #1 check(name, o_dbg_data, exp);
    endtask

    always @(posedge spi.o_miso_oe) oe_rises++;

    // Write monitor: every change of the write counter must match the next queued write.
    initial begin
        logic [15:0] prev;
        wr_t e;
        prev = 16'd0;
        forever begin
            @(negedge o_sclk);
            if (o_wr_cnt !== prev) begin
                prev = o_wr_cnt;
                if (wr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wr_unexpected: got cnt 0x%0h want no write", o_wr_cnt);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_cnt", o_wr_cnt, e.c);
                    check("last_addr", o_last_addr, e.a);
                    check("last_data", o_last_data, e.d);
                end
            end
        end
    end

    // Read monitor: bits driven by the target are sampled on posedges like the controller would.
    initial begin
        logic [7:0] sh;
        int nb;
        sh = 8'd0;
        nb = 0;
        forever begin
            @(posedge o_sclk);
            if (spi.o_miso_oe === 1'b1) begin
                sh = {sh[6:0], spi.o_miso};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (rd_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rd_unexpected: got 0x%0h want no read", sh);
                    end else begin
                        check("rd_byte", sh, rd_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int oe0;
        o_sclk        = 1'b0;
        rst_n         = 1'b0;
        spi.i_sen_n   = 1'b1;
        spi.i_sda     = 1'b0;
        spi.i_sda_dir = 1'b0;
        i_dbg_addr    = 7'd0;
        #20 rst_n = 1'b1;
        #10;

        check("rst_wr_cnt", o_wr_cnt, 0);
        check("rst_rd_cnt", o_rd_cnt, 0);
        check("rst_last_addr", o_last_addr, 0);
        check("rst_last_data", o_last_data, 0);
        check("rst_contention", o_contention, 0);
        check("rst_oe", spi.o_miso_oe, 0);
        check("rst_miso", spi.o_miso, 0);
        dbg(7'h12, 8'h00, "rst_reg12");
        dbg(7'h1F, 8'h08, "rst_id");

        oe0 = oe_rises;
        push_wr(7'h12, 8'hA5);
        spi_frame(1'b0, 7'h12, 16'hA500, 16, 1'b1);
        check("wr_no_oe", oe_rises - oe0, 0);
        dbg(7'h12, 8'hA5, "reg12_after_wr");

        rd_q.push_back(8'hA5);
        spi_frame(1'b1, 7'h12, 16'h0000, 16, 1'b1);
        exp_rd++;
        check("rd_cnt_1", o_rd_cnt, exp_rd);
        check("oe_after_rd", spi.o_miso_oe, 0);
        check("no_contention", o_contention, 0);

        push_wr(7'h1F, 8'h55);
        spi_frame(1'b0, 7'h1F, 16'h5500, 16, 1'b1);
        rd_q.push_back(8'h08);
        spi_frame(1'b1, 7'h1F, 16'h0000, 16, 1'b1);
        exp_rd++;
        dbg(7'h1F, 8'h08, "id_after_wr");
        check("rd_cnt_2", o_rd_cnt, exp_rd);

        spi_frame(1'b0, 7'h20, 16'h3C00, 12, 1'b1);
        dbg(7'h20, 8'h00, "reg20_abort");
        check("wr_cnt_abort", o_wr_cnt, exp_wr);
        check("oe_after_abort", spi.o_miso_oe, 0);
        push_wr(7'h20, 8'h3C);
        spi_frame(1'b0, 7'h20, 16'h3C00, 16, 1'b1);
        dbg(7'h20, 8'h3C, "reg20_full");

        push_wr(7'h30, 8'h77);
`ifdef AD9122_SPI_STREAM_EN
        push_wr(7'h31, 8'h99);
        spi_frame(1'b0, 7'h30, 16'h7799, 24, 1'b1);
        dbg(7'h31, 8'h99, "reg31_stream");
`else
        spi_frame(1'b0, 7'h30, 16'h7799, 24, 1'b1);
        dbg(7'h31, 8'h00, "reg31_done_ignored");
`endif
        dbg(7'h30, 8'h77, "reg30");
        check("wr_cnt_extra", o_wr_cnt, exp_wr);

        rd_q.push_back(8'hA5);
        spi_frame(1'b1, 7'h12, 16'h0000, 16, 1'b0);
        exp_rd++;
        check("contention_set", o_contention, 1);

        push_wr(7'h00, 8'h20);
        spi_frame(1'b0, 7'h00, 16'h2000, 16, 1'b1);
        dbg(7'h00, 8'h00, "soft_rst_reg00");
        dbg(7'h12, 8'h00, "soft_rst_reg12");
        dbg(7'h20, 8'h00, "soft_rst_reg20");
        dbg(7'h30, 8'h00, "soft_rst_reg30");
        dbg(7'h1F, 8'h08, "soft_rst_id");
        check("contention_sticky", o_contention, 1);
        rd_q.push_back(8'h08);
        spi_frame(1'b1, 7'h1F, 16'h0000, 16, 1'b1);
        exp_rd++;
        check("rd_cnt_end", o_rd_cnt, exp_rd);

`ifdef AD9122_SPI_STREAM_EN
        push_wr(7'h7F, 8'h11);
        push_wr(7'h00, 8'h44);
        spi_frame(1'b0, 7'h7F, 16'h1144, 24, 1'b1);
        dbg(7'h7F, 8'h11, "stream_reg7f");
        dbg(7'h00, 8'h44, "stream_reg00");
`endif

        #20;
        check("wr_q_drained", wr_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);
        check("wr_cnt_final", o_wr_cnt, exp_wr);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
